// File: rtl/fp_addsub_issue_ctrl_pkg.sv
// Shared types for the FP add/sub issue controller.
// Owner encoding, shadow slot layout and default stage count.
package fp_addsub_issue_ctrl_pkg;

  localparam int FADDSUB_STAGES = 3;

  typedef enum logic {
    REQ_DECODE = 1'b0,
    REQ_FMA    = 1'b1
  } faddsub_owner_e;

  typedef struct packed {
    logic           valid;
    faddsub_owner_e owner;
    logic [4:0]     rd;
  } faddsub_slot_t;

endpackage

// File: rtl/fp_addsub_issue_ctrl_arb2.sv
// Two-input arbiter with one-hot grant for the FP add/sub unit.
// FADDSUB_RR_ARB_EN selects round-robin; otherwise requester 1 wins.
module fp_issue_arb2 (
`ifdef FADDSUB_RR_ARB_EN
  input  logic       clk,
  input  logic       rst,
`endif
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

`ifdef FADDSUB_RR_ARB_EN
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt_o = req_i;
    ptr_d = ptr_q;
    if (&req_i) begin
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    end
    // point at whoever lost this round
    if (|gnt_o) begin
      ptr_d = ~gnt_o[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    gnt_o = req_i[1] ? 2'b10 : {1'b0, req_i[0]};
  end
`endif

endmodule

// File: rtl/fp_addsub_issue_ctrl.sv
// Issue/arbitration control and shadow ownership pipeline for FP add/sub.
// Define FADDSUB_RR_ARB_EN for round-robin arbitration.
module fp_addsub_issue_ctrl
  import fp_addsub_issue_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = FADDSUB_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_add_sub,
  input  logic [2:0]            req0_rm,
  input  logic [4:0]            req0_rd,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_add_sub,
  input  logic [2:0]            req1_rm,
  input  logic [4:0]            req1_rd,
  input  logic                  flush,
  input  logic [1:0]            flush_mask,
  output logic                  u_en,
  output logic [NUM_STAGES-1:0] u_clear,
  output logic                  u_p_start,
  output logic                  u_sel,
  output logic                  u_add_sub,
  output logic [2:0]            u_rm,
  output logic [4:0]            u_rd,
  input  logic                  u_p_result,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_rd,
  output logic                  wb_owner,
  output logic [1:0]            inflight,
  output logic                  busy
);

  faddsub_slot_t [NUM_STAGES-1:0] st_q;
  faddsub_slot_t [NUM_STAGES-1:0] st_d;
  faddsub_slot_t                  last;
  logic [1:0]                     req_v;
  logic [1:0]                     gnt;
  logic [NUM_STAGES-1:0]          clr;
  logic [1:0]                     cnt;

  assign last = st_q[NUM_STAGES-1];
  assign u_en = ~(last.valid & ~wb_ready);

  assign req_v = {req1_valid, req0_valid} & {2{u_en & ~flush}};

  fp_issue_arb2 u_arb (
`ifdef FADDSUB_RR_ARB_EN
    .clk   (clk),
    .rst   (rst),
`endif
    .req_i (req_v),
    .gnt_o (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign u_p_start  = |gnt;
  assign u_sel      = gnt[1];

  always_comb begin
    u_add_sub = 1'b0;
    u_rm      = 3'd0;
    u_rd      = 5'd0;
    unique case (1'b1)
      gnt[0]: begin
        u_add_sub = req0_add_sub;
        u_rm      = req0_rm;
        u_rd      = req0_rd;
      end
      gnt[1]: begin
        u_add_sub = req1_add_sub;
        u_rm      = req1_rm;
        u_rd      = req1_rd;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      clr[i] = st_q[i].valid & flush &
               ((st_q[i].owner == REQ_FMA) ? flush_mask[1] : flush_mask[0]);
    end
    // a result accepted this cycle is retired, not killed
    if (wb_ready) begin
      clr[NUM_STAGES-1] = 1'b0;
    end
  end

  assign u_clear = clr;

  always_comb begin
    st_d = st_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (clr[i]) begin
        st_d[i].valid = 1'b0;
      end
    end
    if (u_en) begin
      for (int i = 1; i < NUM_STAGES; i++) begin
        st_d[i]       = st_q[i-1];
        st_d[i].valid = st_q[i-1].valid & ~clr[i-1];
      end
      st_d[0].valid = |gnt;
      st_d[0].owner = gnt[1] ? REQ_FMA : REQ_DECODE;
      st_d[0].rd    = u_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    cnt = 2'd0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      cnt = cnt + 2'(st_q[i].valid);
    end
  end

  assign inflight = cnt;
  assign busy     = |cnt;
  assign wb_valid = last.valid;
  assign wb_rd    = last.rd;
  assign wb_owner = (last.owner == REQ_FMA);

  // unit and shadow must agree on the result slot
  p_result_ok: assert property (
    @(posedge clk) disable iff (!rst) u_p_result == last.valid
  );

endmodule

// File: tb/tb_fp_addsub_issue_ctrl.sv
// Scoreboard bench for fp_addsub_issue_ctrl with an op-level reference model.
// Honours FADDSUB_RR_ARB_EN the same way the design does.
module tb_fp_addsub_issue_ctrl;

  localparam int NS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_add_sub = 1'b0, req1_add_sub = 1'b0;
  logic [2:0] req0_rm = 3'd0, req1_rm = 3'd0;
  logic [4:0] req0_rd = 5'd0, req1_rd = 5'd0;
  logic       flush = 1'b0;
  logic [1:0] flush_mask = 2'b00;
  logic       wb_ready = 1'b0;
  logic       req0_ready, req1_ready;
  logic       u_en, u_p_start, u_sel, u_add_sub;
  logic [NS-1:0] u_clear;
  logic [2:0] u_rm;
  logic [4:0] u_rd;
  logic       u_p_result;
  logic       wb_valid, wb_owner, busy;
  logic [4:0] wb_rd;
  logic [1:0] inflight;

  fp_addsub_issue_ctrl #(.NUM_STAGES(NS)) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_add_sub (req0_add_sub),
    .req0_rm      (req0_rm),
    .req0_rd      (req0_rd),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_add_sub (req1_add_sub),
    .req1_rm      (req1_rm),
    .req1_rd      (req1_rd),
    .flush        (flush),
    .flush_mask   (flush_mask),
    .u_en         (u_en),
    .u_clear      (u_clear),
    .u_p_start    (u_p_start),
    .u_sel        (u_sel),
    .u_add_sub    (u_add_sub),
    .u_rm         (u_rm),
    .u_rd         (u_rd),
    .u_p_result   (u_p_result),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_owner     (wb_owner),
    .inflight     (inflight),
    .busy         (busy)
  );

  // the unit reports a result exactly when the offered slot is live
  assign u_p_result = wb_valid;

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    bit         owner;
    logic [4:0] rd;
    int         pos;
  } op_t;

  typedef struct {
    int         id;
    bit         owner;
    logic [4:0] rd;
  } wb_t;

  op_t mops[$];
  wb_t sb[$];
  int  next_id = 0;
  bit  ptr = 1'b0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;
  bit  pend0 = 1'b0, pend1 = 1'b0, gp0 = 1'b0, gp1 = 1'b0;

  logic          e_en, e_r0, e_r1, e_ps, e_sel, e_as, e_wbv, e_busy;
  logic [2:0]    e_rm;
  logic [4:0]    e_rd;
  logic [NS-1:0] e_clr;
  logic [1:0]    e_inf;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected outputs for the current cycle, then the op list after the edge
  task automatic model();
    bit has_last = 1'b0;
    bit g0 = 1'b0;
    bit g1 = 1'b0;
    int kill[$];
    op_t keep[$];
    foreach (mops[i]) if (mops[i].pos == NS-1) has_last = 1'b1;
    e_wbv  = has_last;
    e_en   = !(has_last && !wb_ready);
    e_inf  = 2'(mops.size());
    e_busy = (mops.size() != 0);
    e_clr  = '0;
    foreach (mops[i]) begin
      if (flush && flush_mask[mops[i].owner] &&
          !(mops[i].pos == NS-1 && wb_ready)) begin
        e_clr[mops[i].pos] = 1'b1;
        kill.push_back(mops[i].id);
      end
    end
    if (e_en && !flush) begin
`ifdef FADDSUB_RR_ARB_EN
      if (req0_valid && req1_valid) begin
        g1 = ptr;
        g0 = !ptr;
      end else begin
        g0 = req0_valid;
        g1 = req1_valid;
      end
      if (g0 || g1) ptr = g0;
`else
      g1 = req1_valid;
      g0 = req0_valid && !req1_valid;
`endif
    end
    e_r0  = g0;
    e_r1  = g1;
    e_ps  = g0 | g1;
    e_sel = g1;
    e_as  = g0 ? req0_add_sub : (g1 ? req1_add_sub : 1'b0);
    e_rm  = g0 ? req0_rm : (g1 ? req1_rm : 3'd0);
    e_rd  = g0 ? req0_rd : (g1 ? req1_rd : 5'd0);
    foreach (mops[i]) begin
      bit dead = 1'b0;
      foreach (kill[k]) if (kill[k] == mops[i].id) dead = 1'b1;
      if (!dead) keep.push_back(mops[i]);
    end
    foreach (kill[k]) begin
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].id == kill[k]) sb.delete(j);
      end
    end
    mops = keep;
    if (has_last && wb_ready) void'(mops.pop_front());
    if (e_en) foreach (mops[i]) mops[i].pos++;
    if (g0 || g1) begin
      mops.push_back('{next_id, g1, e_rd, 0});
      sb.push_back('{next_id, g1, e_rd});
      next_id++;
    end
  endtask

  task automatic tick(bit v0, bit v1, bit fl, logic [1:0] m, bit wr);
    @(posedge clk);
    #1;
    if (gp0) begin
      req0_add_sub = 1'($urandom_range(1, 0));
      req0_rm      = 3'($urandom_range(7, 0));
      req0_rd      = 5'($urandom_range(31, 0));
    end
    if (gp1) begin
      req1_add_sub = 1'($urandom_range(1, 0));
      req1_rm      = 3'($urandom_range(7, 0));
      req1_rd      = 5'($urandom_range(31, 0));
    end
    req0_valid = v0 | pend0;
    req1_valid = v1 | pend1;
    flush      = fl;
    flush_mask = m;
    wb_ready   = wr;
    model();
    gp0    = e_r0;
    gp1    = e_r1;
    pend0  = req0_valid && !e_r0;
    pend1  = req1_valid && !e_r1;
    chk_en = 1'b1;
  endtask

  task automatic drain();
    repeat (6) tick(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic chk_reset();
    chk("rst_u_en", u_en, 1);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_owner", wb_owner, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_busy", busy, 0);
    chk("rst_u_clear", u_clear, 0);
    chk("rst_u_p_start", u_p_start, 0);
    chk("rst_u_sel", u_sel, 0);
    chk("rst_u_rd", u_rd, 0);
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      wb_t w;
      chk("u_en", u_en, e_en);
      chk("req0_ready", req0_ready, e_r0);
      chk("req1_ready", req1_ready, e_r1);
      chk("u_p_start", u_p_start, e_ps);
      chk("u_sel", u_sel, e_sel);
      chk("u_add_sub", u_add_sub, e_as);
      chk("u_rm", u_rm, e_rm);
      chk("u_rd", u_rd, e_rd);
      chk("u_clear", u_clear, e_clr);
      chk("wb_valid", wb_valid, e_wbv);
      chk("inflight", inflight, e_inf);
      chk("busy", busy, e_busy);
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          w = sb.pop_front();
          chk("wb_rd", wb_rd, w.rd);
          chk("wb_owner", wb_owner, w.owner);
        end
      end
    end
  end

  initial begin
    #3;
    chk_reset();
    @(posedge clk);
    #2 rst = 1'b1;

    req0_rd = 5'd5;
    tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    repeat (4) tick(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    drain();

    repeat (3) tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    drain();

    tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 2'b01, 1'b0);
    drain();

    tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 2'b01, 1'b1);
    drain();

    tick(1'b1, 1'b0, 1'b0, 2'b00, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 2'b00, 1'b1);
    chk_en     = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst        = 1'b0;
    #1;
    chk_reset();
    mops.delete();
    sb.delete();
    ptr   = 1'b0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    gp0   = 1'b0;
    gp1   = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (5) tick(1'b0, 1'b0, 1'b0, 2'b00, 1'b1);

    repeat (400) begin
      tick(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           ($urandom_range(11, 0) == 0), 2'($urandom_range(3, 0)),
           ($urandom_range(3, 0) != 0));
    end
    drain();
    @(negedge clk);
    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
